// File: rtl/axi_uram_arb2.sv
// Two-master AXI4 front end for axi_uram: round-robin AR/AW, source-bit ID tagging, grant-ordered W steering.
// Define AXI_URAM_ARB_QOS_EN to let the strictly higher AxQOS win ahead of round-robin.
module axi_uram_arb2 #(
    parameter int C_S_AXI_ID_WIDTH      = 8,
    parameter int C_S_AXI_ADDR_WIDTH    = 20,
    parameter int C_S_AXI_DATA_WIDTH    = 1024,
    parameter int MAX_OUTSTANDING_TRANX = 16,
    localparam int AXW = C_S_AXI_ID_WIDTH + C_S_AXI_ADDR_WIDTH + 8 + 3 + 2,
    localparam int WW  = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH / 8 + 1
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,

    input  logic [1:0]                    s_arvalid,
    output logic [1:0]                    s_arready,
    input  logic [2*AXW-1:0]              s_ar,
    input  logic [1:0]                    s_awvalid,
    output logic [1:0]                    s_awready,
    input  logic [2*AXW-1:0]              s_aw,
    input  logic [1:0]                    s_wvalid,
    output logic [1:0]                    s_wready,
    input  logic [2*WW-1:0]               s_w,
    output logic [1:0]                    s_rvalid,
    input  logic [1:0]                    s_rready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [1:0]                    s_bvalid,
    input  logic [1:0]                    s_bready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_bid,
    output logic [1:0]                    s_bresp,
    input  logic [7:0]                    s_arqos,
    input  logic [7:0]                    s_awqos,

    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [AXW:0]                  m_ar,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [AXW:0]                  m_aw,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [WW-1:0]                 m_w,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [C_S_AXI_ID_WIDTH:0]     m_rid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    input  logic [C_S_AXI_ID_WIDTH:0]     m_bid,
    input  logic [1:0]                    m_bresp
);

    localparam int PW = $clog2(MAX_OUTSTANDING_TRANX);

    logic ar_free, ar_go, ar_win, ar_ptr;
    logic aw_free, aw_go, aw_win, aw_ptr;
    logic [MAX_OUTSTANDING_TRANX-1:0] wq_mem;
    logic [PW-1:0] wq_rd, wq_wr;
    logic [PW:0]   wq_cnt;
    logic wq_full, wq_empty, w_head, w_pop;
    logic r_sel, b_sel;

`ifdef AXI_URAM_ARB_QOS_EN
    function automatic logic pick(input logic [1:0] req, input logic ptr,
                                  input logic [3:0] q0, input logic [3:0] q1);
        if (req != 2'b11) return req[1];
        if (q1 > q0)      return 1'b1;
        if (q0 > q1)      return 1'b0;
        return ptr;
    endfunction

    assign ar_win = pick(s_arvalid, ar_ptr, s_arqos[3:0], s_arqos[7:4]);
    assign aw_win = pick(s_awvalid, aw_ptr, s_awqos[3:0], s_awqos[7:4]);
`else
    function automatic logic pick(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

    logic unused_qos;
    assign unused_qos = ^{s_arqos, s_awqos};
    assign ar_win = pick(s_arvalid, ar_ptr);
    assign aw_win = pick(s_awvalid, aw_ptr);
`endif

    assign ar_free   = !m_arvalid || m_arready;
    assign ar_go     = s_axi_aresetn && ar_free && (|s_arvalid);
    assign s_arready = ar_go ? (ar_win ? 2'b10 : 2'b01) : 2'b00;

    // Full comes from the registered count, so a push never meets a pop on a full FIFO.
    assign wq_full   = wq_cnt[PW];
    assign wq_empty  = (wq_cnt == '0);
    assign aw_free   = !m_awvalid || m_awready;
    assign aw_go     = s_axi_aresetn && aw_free && !wq_full && (|s_awvalid);
    assign s_awready = aw_go ? (aw_win ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_arvalid <= 1'b0;
            m_ar      <= '0;
            ar_ptr    <= 1'b0;
        end else if (ar_free) begin
            m_arvalid <= ar_go;
            if (ar_go) begin
                m_ar   <= {ar_win, ar_win ? s_ar[2*AXW-1:AXW] : s_ar[AXW-1:0]};
                ar_ptr <= ~ar_win;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_awvalid <= 1'b0;
            m_aw      <= '0;
            aw_ptr    <= 1'b0;
        end else if (aw_free) begin
            m_awvalid <= aw_go;
            if (aw_go) begin
                m_aw   <= {aw_win, aw_win ? s_aw[2*AXW-1:AXW] : s_aw[AXW-1:0]};
                aw_ptr <= ~aw_win;
            end
        end
    end

    assign w_head   = wq_mem[wq_rd];
    assign m_w      = w_head ? s_w[2*WW-1:WW] : s_w[WW-1:0];
    assign m_wvalid = !wq_empty && s_wvalid[w_head];
    assign s_wready = (wq_empty || !m_wready) ? 2'b00 : (w_head ? 2'b10 : 2'b01);
    assign w_pop    = m_wvalid && m_wready && m_w[0];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wq_mem <= '0;
            wq_rd  <= '0;
            wq_wr  <= '0;
            wq_cnt <= '0;
        end else begin
            if (aw_go) begin
                wq_mem[wq_wr] <= aw_win;
                wq_wr         <= wq_wr + PW'(1);
            end
            if (w_pop) wq_rd <= wq_rd + PW'(1);
            case ({aw_go, w_pop})
                2'b10:   wq_cnt <= wq_cnt + (PW+1)'(1);
                2'b01:   wq_cnt <= wq_cnt - (PW+1)'(1);
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    // Responses are steered by the source bit the arbiter prepended to the ID.
    assign r_sel    = m_rid[C_S_AXI_ID_WIDTH];
    assign s_rvalid = (s_axi_aresetn && m_rvalid) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign m_rready = s_axi_aresetn && s_rready[r_sel];
    assign s_rid    = m_rid[C_S_AXI_ID_WIDTH-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    assign b_sel    = m_bid[C_S_AXI_ID_WIDTH];
    assign s_bvalid = (s_axi_aresetn && m_bvalid) ? (b_sel ? 2'b10 : 2'b01) : 2'b00;
    assign m_bready = s_axi_aresetn && s_bready[b_sel];
    assign s_bid    = m_bid[C_S_AXI_ID_WIDTH-1:0];
    assign s_bresp  = m_bresp;

endmodule

// File: tb/tb_axi_uram_arb2.sv
// Randomized + directed bench for axi_uram_arb2 against a queue-based behavioural model.
module tb_axi_uram_arb2;
    localparam int IDW   = 8;
    localparam int ADW   = 20;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AXW   = IDW + ADW + 13;
    localparam int WW    = DW + DW / 8 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0] s_rvalid, s_rready, s_bvalid, s_bready, s_rresp, s_bresp;
    logic [2*AXW-1:0] s_ar, s_aw;
    logic [2*WW-1:0]  s_w;
    logic [IDW-1:0]   s_rid, s_bid;
    logic [DW-1:0]    s_rdata, m_rdata;
    logic             s_rlast, m_rlast;
    logic [7:0]       s_arqos, s_awqos;
    logic             m_arvalid, m_arready, m_awvalid, m_awready, m_wvalid, m_wready;
    logic [AXW:0]     m_ar, m_aw;
    logic [WW-1:0]    m_w;
    logic             m_rvalid, m_rready, m_bvalid, m_bready;
    logic [IDW:0]     m_rid, m_bid;
    logic [1:0]       m_rresp, m_bresp;

    axi_uram_arb2 #(
        .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(ADW),
        .C_S_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING_TRANX(DEPTH)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arqos(s_arqos), .s_awqos(s_awqos),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: one pending output beat per channel, last winner per channel, queue of AW sources.
    logic         ar_mv, aw_mv;
    logic [AXW:0] ar_mp, aw_mp;
    int           ar_last, aw_last;
    int           wq[$];

    function automatic int winner(input logic [1:0] req, input int last,
                                  input logic [3:0] q0, input logic [3:0] q1);
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
`ifdef AXI_URAM_ARB_QOS_EN
        if (q0 > q1) return 0;
        if (q1 > q0) return 1;
`endif
        return 1 - last;
    endfunction

    always @(negedge clk) begin : cmp
        int w, h;
        logic free, pop, push, sel;
        logic [1:0] er;
        logic [WW-1:0] ws;
        if (!rst_n) begin
            ar_mv = 1'b0; aw_mv = 1'b0; ar_mp = '0; aw_mp = '0;
            ar_last = 1; aw_last = 1;
            wq.delete();
        end else begin
            free = !ar_mv || m_arready;
            er = 2'b00; w = 0;
            if (free && (|s_arvalid)) begin
                w = winner(s_arvalid, ar_last, s_arqos[3:0], s_arqos[7:4]);
                er = (w == 1) ? 2'b10 : 2'b01;
            end
            chk("m_arvalid", m_arvalid, ar_mv);
            if (ar_mv) chk("m_ar", m_ar, ar_mp);
            chk("s_arready", s_arready, er);
            if (free) begin
                ar_mv = |s_arvalid;
                if (|s_arvalid) begin
                    ar_mp = {w == 1, (w == 1) ? s_ar[2*AXW-1:AXW] : s_ar[AXW-1:0]};
                    ar_last = w;
                end
            end

            free = (!aw_mv || m_awready) && (wq.size() < DEPTH);
            er = 2'b00; w = 0; push = 1'b0;
            if (free && (|s_awvalid)) begin
                w = winner(s_awvalid, aw_last, s_awqos[3:0], s_awqos[7:4]);
                er = (w == 1) ? 2'b10 : 2'b01;
                push = 1'b1;
            end
            chk("m_awvalid", m_awvalid, aw_mv);
            if (aw_mv) chk("m_aw", m_aw, aw_mp);
            chk("s_awready", s_awready, er);

            pop = 1'b0;
            if (wq.size() == 0) begin
                chk("m_wvalid_idle", m_wvalid, 1'b0);
                chk("s_wready_idle", s_wready, 2'b00);
            end else begin
                h = wq[0];
                ws = (h == 1) ? s_w[2*WW-1:WW] : s_w[WW-1:0];
                chk("m_wvalid", m_wvalid, s_wvalid[h]);
                chk("m_w", m_w, ws);
                chk("s_wready", s_wready, m_wready ? ((h == 1) ? 2'b10 : 2'b01) : 2'b00);
                pop = s_wvalid[h] && m_wready && ws[0];
            end
            if (pop) void'(wq.pop_front());
            if (push) wq.push_back(w);
            if (!aw_mv || m_awready) begin
                aw_mv = push;
                if (push) begin
                    aw_mp = {w == 1, (w == 1) ? s_aw[2*AXW-1:AXW] : s_aw[AXW-1:0]};
                    aw_last = w;
                end
            end

            sel = m_rid[IDW];
            chk("s_rvalid", s_rvalid, m_rvalid ? (sel ? 2'b10 : 2'b01) : 2'b00);
            chk("m_rready", m_rready, s_rready[sel]);
            chk("s_r_fields", {s_rid, s_rdata, s_rresp, s_rlast}, {m_rid[IDW-1:0], m_rdata, m_rresp, m_rlast});
            sel = m_bid[IDW];
            chk("s_bvalid", s_bvalid, m_bvalid ? (sel ? 2'b10 : 2'b01) : 2'b00);
            chk("m_bready", m_bready, s_bready[sel]);
            chk("s_b_fields", {s_bid, s_bresp}, {m_bid[IDW-1:0], m_bresp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_inputs();
        logic [127:0] a, b, c;
        a = rnd128(); s_ar = a[2*AXW-1:0];
        a = rnd128(); s_aw = a[2*AXW-1:0];
        a = rnd128(); b = rnd128(); c = {a[63:0], b[63:0]};
        s_w = {b[127:64], a[127:64], c[17:0]};
        s_arvalid = 2'($urandom); s_awvalid = 2'($urandom); s_wvalid = 2'($urandom);
        s_rready = 2'($urandom); s_bready = 2'($urandom);
        s_arqos = 8'($urandom); s_awqos = 8'($urandom);
        m_arready = ($urandom_range(0, 3) != 0);
        m_awready = ($urandom_range(0, 3) != 0);
        m_wready  = ($urandom_range(0, 3) != 0);
        m_rvalid = 1'($urandom); m_bvalid = 1'($urandom);
        m_rid = 9'($urandom); m_bid = 9'($urandom);
        a = rnd128(); m_rdata = a[63:0];
        m_rresp = 2'($urandom); m_bresp = 2'($urandom); m_rlast = 1'($urandom);
    endtask

    logic [AXW:0]  bp_exp;
    logic [WW-1:0] w0, w1;

    initial begin
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0; s_rready = 0; s_bready = 0;
        s_ar = '0; s_aw = '0; s_w = '0; s_arqos = 0; s_awqos = 0;
        m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
        m_rid = '0; m_bid = '0; m_rdata = '0; m_rresp = 0; m_bresp = 0; m_rlast = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_awvalid", m_awvalid, 1'b0);
        chk("rst_m_wvalid", m_wvalid, 1'b0);
        chk("rst_m_ar", m_ar, '0);

        // Round-robin with both masters requesting
        tick();
        s_arvalid = 2'b11; m_arready = 1'b1;
        s_ar = {41'h1_2345_6789_B1, 41'h0_0ABC_DEF0_A0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", s_arready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk("rr_m_arvalid", m_arvalid, 1'b1);
                chk("rr_m_ar_src", m_ar[AXW], ((k - 1) % 2) == 1);
            end
            tick();
        end
        s_arvalid = 2'b00;

        // R routing
        m_rid = 9'h105; m_rvalid = 1'b1; s_rready = 2'b10;
        #1;
        chk("r_route_valid", s_rvalid, 2'b10);
        chk("r_route_id", s_rid, 8'h05);
        chk("r_route_ready", m_rready, 1'b1);
        s_rready = 2'b01;
        #1 chk("r_route_ready_other", m_rready, 1'b0);
        m_rvalid = 1'b0;

        repeat (3000) begin
            tick();
            rand_inputs();
        end

        // Drain the write-order FIFO
        tick();
        s_arvalid = 0; s_awvalid = 0; m_arready = 1; m_awready = 1;
        m_rvalid = 0; m_bvalid = 0; m_wready = 1; s_wvalid = 2'b11;
        s_arqos = 0; s_awqos = 0;
        s_w = '0; s_w[0] = 1'b1; s_w[WW] = 1'b1;
        repeat (20) tick();
        #1 chk("drain_empty", m_wvalid, 1'b0);

        // W ordering: AW m1 (4 beats) then AW m0 (1 beat); m0 data arrives first
        tick();
        s_wvalid = 2'b01; w0 = {64'hAA, 8'hFF, 1'b1}; s_w = {73'h0, w0};
        s_awvalid = 2'b10; s_aw = '0; s_aw[AXW+5 +: 8] = 8'd3;
        #1 chk("word_aw_m1", s_awready, 2'b10);
        tick();
        s_awvalid = 2'b01; s_aw = '0;
        #1;
        chk("word_aw_m0", s_awready, 2'b01);
        chk("word_m0_stall_ready", s_wready, 2'b10);
        chk("word_m0_stall_valid", m_wvalid, 1'b0);
        tick();
        s_awvalid = 2'b00; s_wvalid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            w1 = {64'(b + 1), 8'h0F, b == 3};
            s_w = {w1, w0};
            #1;
            chk("word_m1_ready", s_wready, 2'b10);
            chk("word_m1_valid", m_wvalid, 1'b1);
            chk("word_m1_data", m_w, w1);
            tick();
        end
        #1;
        chk("word_m0_ready", s_wready, 2'b01);
        chk("word_m0_data", m_w, w0);
        tick();
        s_wvalid = 2'b00;
        #1 chk("word_done", m_wvalid, 1'b0);

        // FIFO full after 16 AWs without W traffic
        tick();
        s_awvalid = 2'b01; m_awready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1 chk("full_grant", s_awready, 2'b01);
            tick();
        end
        #1 chk("full_block", s_awready, 2'b00);
        s_wvalid = 2'b01; s_w = {73'h0, w0}; m_wready = 1'b1;
        tick();
        s_wvalid = 2'b00;
        #1 chk("full_reopen", s_awready, 2'b01);

        // AR backpressure
        tick();
        s_awvalid = 2'b00; m_awready = 1'b0;
        s_arvalid = 2'b00; m_arready = 1'b1;
        tick();
        s_arvalid = 2'b01; m_arready = 1'b0;
        s_ar = {41'h0_1111_2222_33, 41'h1_5555_6666_7C};
        bp_exp = {1'b0, s_ar[AXW-1:0]};
        #1 chk("bp_first", s_arready, 2'b01);
        tick();
        s_arvalid = 2'b11; s_ar = {41'h1_0F0F_0F0F_0F, 41'h0_F0F0_F0F0_F0};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", s_arready, 2'b00);
            chk("bp_valid", m_arvalid, 1'b1);
            chk("bp_hold", m_ar, bp_exp);
            tick();
        end

        // Reset mid-burst
        s_wvalid = 2'b01; s_w = '0; m_wready = 1'b0;
        #1;
        chk("pre_rst_ar", m_arvalid, 1'b1);
        chk("pre_rst_aw", m_awvalid, 1'b1);
        chk("pre_rst_w", m_wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ar", m_arvalid, 1'b0);
        chk("rst_mid_aw", m_awvalid, 1'b0);
        chk("rst_mid_w", m_wvalid, 1'b0);
        chk("rst_mid_arready", s_arready, 2'b00);
        repeat (2) tick();
        rst_n = 1'b1;
        s_arvalid = 0; s_wvalid = 0;

`ifdef AXI_URAM_ARB_QOS_EN
        tick();
        s_arvalid = 2'b11; m_arready = 1'b1; s_arqos = {4'd7, 4'd2};
        for (int k = 0; k < 4; k++) begin
            #1 chk("qos_high_wins", s_arready, 2'b10);
            tick();
        end
        s_arqos = {4'd5, 4'd5};
        for (int k = 0; k < 4; k++) begin
            #1 chk("qos_equal_rr", s_arready, (k % 2) ? 2'b10 : 2'b01);
            tick();
        end
`endif

        repeat (1000) begin
            tick();
            rand_inputs();
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_uram_arb2.md
# axi_uram_arb2

Two-master AXI4 arbiter placed in front of `axi_uram` in `mem_subsys`. It lets two requesters share the single URAM slave port. AR and AW are arbitrated independently with round-robin. Each granted request is tagged by widening the ID with a source bit, and R/B responses are routed back on that bit. A write-order FIFO steers W beats from the master whose AW was granted, in grant order.

## Interface
- `C_S_AXI_ID_WIDTH`, 8: ID width per slave port; master-side ID is `C_S_AXI_ID_WIDTH+1`.
- `C_S_AXI_ADDR_WIDTH`, 20: address width.
- `C_S_AXI_DATA_WIDTH`, 1024: data width.
- `MAX_OUTSTANDING_TRANX`, 16: write-order FIFO depth (power of 2).
- Derived widths, all `{...}` concatenations listed MSB first:
  - `AXW` = ID+ADDR+8+3+2: address payload `{id,addr,len,size,burst}`.
  - `WW` = DATA+DATA/8+1: write payload `{wdata,wstrb,wlast}`.
- Ports; the first two lines are fixed: one clock; reset is asynchronous and active-low.
- `s_axi_aclk` in 1: the only clock.
- `s_axi_aresetn` in 1: asynchronous, active-low reset.
- `s_arvalid`/`s_arready` in/out 2: per-master AR handshake; bit i = master i.
- `s_ar` in 2*AXW: packed AR payloads; master i in slice i.
- `s_awvalid`/`s_awready` in/out 2, and `s_aw` in 2*AXW: same as AR, for AW.
- `s_wvalid`/`s_wready` in/out 2, and `s_w` in 2*WW: per-master W.
- `s_rvalid`/`s_rready` out/in 2: per-master R handshake.
- `s_rid` out ID, `s_rdata` out DATA, `s_rresp` out 2, `s_rlast` out 1: R fields broadcast to both masters.
- `s_bvalid`/`s_bready` out/in 2: per-master B handshake.
- `s_bid` out ID, `s_bresp` out 2: B fields broadcast to both masters.
- `s_arqos`/`s_awqos` in 2*4: used only under QoS config.
- `m_arvalid`/`m_arready` out/in 1, `m_ar` out AXW+1: to `axi_uram`; ID field = `{src,id}`.
- `m_awvalid`/`m_awready` out/in 1, `m_aw` out AXW+1: same as AR.
- `m_wvalid`/`m_wready` out/in 1, `m_w` out WW: W to `axi_uram`.
- `m_rvalid`/`m_rready` in/out 1, `m_rid` in ID+1, `m_rdata`/`m_rresp`/`m_rlast` in: R from `axi_uram`.
- `m_bvalid`/`m_bready` in/out 1, `m_bid` in ID+1, `m_bresp` in 2: B from `axi_uram`.

## Operation
- **AR/AW output slot.** Each channel has a one-entry registered output slot (`m_*valid` plus payload). The slot is "free" when `!m_*valid || m_*ready`.
- **Grant.**
  - Each cycle the slot is free, the arbiter grants one requesting master.
  - `s_*ready[i]` = grant[i] & free. It is combinational, and 0 for a non-requesting master.
  - The winner's payload is loaded with the source bit i prepended to the ID.
- **Round-robin.** A 1-bit priority pointer per channel. After a grant to i, priority goes to 1-i. If only one master requests, it wins regardless of the pointer.
- **AW gating.** AW grant is also gated by write-order FIFO not full. Each AW grant pushes the source index into the FIFO.
- **W steering.**
  - While the FIFO is non-empty, the head index h selects the master: `m_w` = slice h of `s_w`, `m_wvalid` = `s_wvalid[h]`, `s_wready[h]` = `m_wready`.
  - The other master's `s_wready` = 0.
  - The FIFO pops on `m_wvalid & m_wready & wlast`.
  - While the FIFO is empty, `m_wvalid` = 0 and `s_wready` = 0. W arriving ahead of its AW waits.
- **R/B routing.**
  - sel = MSB of `m_rid` (resp. `m_bid`).
  - `s_rvalid[sel]` = `m_rvalid`, `m_rready` = `s_rready[sel]`.
  - ID low bits and data are broadcast; the non-selected valid is 0.
- **No other state.** Bursts are never split. The arbiter does not track outstanding reads.

## Timing
- **Reset values.**
  - `m_arvalid`=`m_awvalid`=0; payload registers 0.
  - Priority pointers = master 0; FIFO empty.
  - All `s_*ready`, `s_*valid`, `m_wvalid`, `m_rready`, `m_bready` = 0.
- **Latency.** `s_ar` handshake in cycle N gives `m_arvalid` in N+1; same for AW. Sustained throughput is 1 grant/cycle per channel when `m_*ready` is held high.
- **W, R, B paths.** Zero added latency (combinational).
- **Simultaneous events.**
  - Simultaneous requests are resolved by the pointer.
  - A push and pop in the same cycle on a full FIFO is not allowed: AW gating uses the registered full flag.
  - A push and pop on a non-full FIFO are both performed.
- **Hold rule.** The payload is held stable while `m_*valid` && !`m_*ready`.
- **Reset mid-burst.** Reset drops all valids immediately, asynchronously. No transaction is replayed.

## Configuration
- `AXI_URAM_ARB_QOS_EN`:
  - When defined, the master with the strictly higher `s_arqos`/`s_awqos` among requesters wins. Round-robin applies only on equal QoS, and the pointer advances as usual.
  - When undefined, the QoS ports are ignored (unconnected internally) and the arbiter is pure round-robin.

## Test plan
- **Round-robin.** Both masters hold `arvalid`, `m_arready`=1 → grants alternate 0,1,0,1; `m_ar` ID MSB matches the source; one grant per cycle.
- **R routing.** `m_rid`=9'h105, `m_rvalid`=1 → `s_rvalid`=2'b10, `s_rid`=8'h05; `m_rready` follows `s_rready[1]`.
- **W ordering.**
  - AW from m1 (len 3), then AW from m0 (len 0). m0 asserts `wvalid` first.
  - Required: m0 stalled until m1's 4 beats pass, then m0's single beat is forwarded.
- **FIFO full.**
  - 16 AWs granted with no W traffic → `s_awready` = 0 on the 17th request.
  - After one `wlast` pops the FIFO, the next AW is granted.
- **Backpressure and reset.**
  - `m_arready`=0 for 5 cycles → `m_ar` stable and `s_arready`=0.
  - Asserting `s_axi_aresetn`=0 mid-burst clears `m_arvalid`/`m_awvalid`/`m_wvalid` immediately.
- **QoS (`AXI_URAM_ARB_QOS_EN`).** m0 `qos`=2, m1 `qos`=7, both requesting → m1 wins every cycle; with equal QoS → alternation.
